// File: rtl/cpu_pkg.sv
// Shared definitions for the mini-CPU: FSM state encodings, access sizes and
// default memory geometry.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_HALF = 1'b1;

endpackage

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: byte or little-endian halfword requests turned into single-byte
// memory accesses. Optional LSU_WRAP_FAULT_EN faults halfword accesses at the top address.
module lsu_mem_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_size,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [2*DATA_W-1:0] resp_rdata,
    output logic                resp_err,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wd,
    input  logic [DATA_W-1:0]   mem_rd
);

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StLo   = ST_LO,
        StHi   = ST_HI,
        StResp = ST_RESP
    } state_e;

    state_e              state;
    logic                we_q;
    logic                size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [2*DATA_W-1:0] wdata_q;
    logic [2*DATA_W-1:0] rdata_q;
    logic                resp_valid_q;
    logic                err_q;
    logic [ADDR_W-1:0]   hi_addr;
    logic                wrap_fault;

    // High byte address wraps naturally modulo 2^ADDR_W.
    assign hi_addr = addr_q + ADDR_W'(1);

`ifdef LSU_WRAP_FAULT_EN
    assign wrap_fault = (req_size == SIZE_HALF) && (req_addr == {ADDR_W{1'b1}});
`else
    assign wrap_fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            addr_q       <= '0;
            last_addr_q  <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= wrap_fault;
                        if (wrap_fault) begin
                            state        <= StResp;
                            resp_valid_q <= 1'b1;
                        end else begin
                            state <= StLo;
                        end
                    end
                end
                StLo: begin
                    last_addr_q <= addr_q;
                    if (!we_q) rdata_q[DATA_W-1:0] <= mem_rd;
                    if (size_q == SIZE_HALF) begin
                        state <= StHi;
                    end else begin
                        state        <= StResp;
                        resp_valid_q <= 1'b1;
                    end
                end
                StHi: begin
                    last_addr_q <= hi_addr;
                    if (!we_q) rdata_q[2*DATA_W-1:DATA_W] <= mem_rd;
                    state        <= StResp;
                    resp_valid_q <= 1'b1;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state        <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign req_ready  = (state == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Outside LO/HI the address bus keeps the last byte actually accessed.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = last_addr_q;
        mem_wd   = '0;
        unique case (state)
            StLo: begin
                mem_we   = we_q;
                mem_addr = addr_q;
                mem_wd   = wdata_q[DATA_W-1:0];
            end
            StHi: begin
                mem_we   = we_q;
                mem_addr = hi_addr;
                mem_wd   = wdata_q[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

endmodule
